// File: rtl/tx_tlp_mux_pkg.sv
// Tx_Arbiter_Package: source and state encodings, beat geometry, and last-beat keep helper.
package Tx_Arbiter_Package;
   localparam int DATA_WIDTH  = 128;
   localparam int DW_PER_BEAT = 4;
   typedef enum logic [1:0] {A2P_1 = 2'd0, A2P_2 = 2'd1, MASTER = 2'd2, RX_ROUTER = 2'd3} src_e;
   typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2, DRAIN = 2'd3} state_e;
   typedef struct packed {
      logic       sop;
      logic       eop;
      logic [3:0] keep;
   } beat_meta_t;
   function automatic logic [3:0] last_keep(input logic [1:0] rem);
      return rem == 2'd0 ? 4'hF : ~(4'hF << rem);
   endfunction
endpackage

// File: rtl/tx_tlp_mux_if.sv
// tx_tlp_mux_if: grant, source-read and downstream TLP signals of the TX mux.
interface tx_tlp_mux_if #(parameter int DATA_WIDTH = 128);
   logic                    grant_valid;
   logic [1:0]              grant_src;
   logic [10:0]             grant_len;
   logic                    grant_ready;
   logic                    grant_done;
   logic [3:0]              src_rd_en;
   logic                    src_rd_hdr;
   logic [4*DATA_WIDTH-1:0] src_rdata;
   logic                    tlp_valid;
   logic                    tlp_ready;
   logic [DATA_WIDTH-1:0]   tlp_data;
   logic                    tlp_sop;
   logic                    tlp_eop;
   logic [3:0]              tlp_keep;
   modport slave (
      input  grant_valid, grant_src, grant_len, src_rdata, tlp_ready,
      output grant_ready, grant_done, src_rd_en, src_rd_hdr, tlp_valid, tlp_data, tlp_sop, tlp_eop, tlp_keep
   );
   modport master (
      output grant_valid, grant_src, grant_len, src_rdata, tlp_ready,
      input  grant_ready, grant_done, src_rd_en, src_rd_hdr, tlp_valid, tlp_data, tlp_sop, tlp_eop, tlp_keep
   );
endinterface

// File: rtl/tx_tlp_mux_skid.sv
// tx_tlp_mux_skid: 2-entry FIFO between source read data and the downstream handshake.
module tx_tlp_mux_skid #(parameter int W = 134) (
   input  logic         clk,
   input  logic         arst,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o,
   output logic [1:0]   cnt_o
);
   logic [W-1:0] mem_q [2];
   logic         wp_q, rp_q, pop;
   logic [1:0]   cnt_q;
   assign valid_o = cnt_q != 2'd0;
   assign pop     = valid_o & ready_i;
   assign data_o  = valid_o ? mem_q[rp_q] : '0;
   assign cnt_o   = cnt_q;
   always_ff @(posedge clk)
      if (push_i) mem_q[wp_q] <= data_i;
   always_ff @(posedge clk or negedge arst)
      if (!arst) begin
         wp_q  <= 1'b0;
         rp_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         wp_q  <= wp_q ^ push_i;
         rp_q  <= rp_q ^ pop;
         cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop};
      end
endmodule

// File: rtl/tx_tlp_mux.sv
// tx_tlp_mux: reads header then payload of the granted source into a skid and streams it as one TLP.
module tx_tlp_mux #(
   parameter int DATA_WIDTH = Tx_Arbiter_Package::DATA_WIDTH,
   parameter int MAX_LEN_DW = 1024
) (
   input logic         clk,
   input logic         arst,
   tx_tlp_mux_if.slave bus
);
   import Tx_Arbiter_Package::*;
   localparam int BW = $clog2(MAX_LEN_DW / DW_PER_BEAT) + 1;
   localparam int SW = DATA_WIDTH + $bits(beat_meta_t);
   state_e                state_q, state_d;
   src_e                  src_q, src_d;
   logic [10:0]           len_q, len_d;
   logic [BW-1:0]         beats_q, beats_d;
   logic                  rd_q, rd, pop, permit, last;
   beat_meta_t            rd_meta_q, rd_meta_d, out_meta;
   logic [1:0]            cnt;
   logic [DATA_WIDTH-1:0] rdata;
   logic [SW-1:0]         skid_out;
   // a read may only issue if its data is guaranteed a free skid slot on arrival
   assign pop    = bus.tlp_valid & bus.tlp_ready;
   assign permit = ({1'b0, cnt} - {2'b0, pop} + {2'b0, rd_q}) < 3'd2;
   assign rd     = permit & (state_q == HDR | state_q == DATA);
   assign last   = beats_q == BW'(1);
   assign rdata  = bus.src_rdata[src_q*DATA_WIDTH +: DATA_WIDTH];
   assign bus.grant_ready = state_q == IDLE;
   assign bus.grant_done  = state_q == DRAIN & pop & bus.tlp_eop;
   assign bus.src_rd_en   = rd ? 4'(1) << src_q : 4'b0;
   assign bus.src_rd_hdr  = rd & state_q == HDR;
   always_comb begin
      rd_meta_d.sop  = state_q == HDR;
      rd_meta_d.eop  = state_q == HDR ? len_q == 11'd0 : last;
      rd_meta_d.keep = (state_q == DATA && last) ? last_keep(len_q[1:0]) : 4'hF;
   end
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      len_d   = len_q;
      beats_d = beats_q;
      if (state_q == IDLE && bus.grant_valid) begin
         state_d = HDR;
         src_d   = src_e'(bus.grant_src);
         len_d   = bus.grant_len;
         beats_d = BW'((bus.grant_len + 11'd3) >> 2);
      end
      if (state_q == HDR && rd) state_d = beats_q != '0 ? DATA : DRAIN;
      if (state_q == DATA && rd) begin
         beats_d = beats_q - BW'(1);
         state_d = last ? DRAIN : DATA;
      end
      if (state_q == DRAIN && bus.grant_done) state_d = IDLE;
   end
   always_ff @(posedge clk or negedge arst)
      if (!arst) begin
         state_q   <= IDLE;
         src_q     <= A2P_1;
         len_q     <= '0;
         beats_q   <= '0;
         rd_q      <= 1'b0;
         rd_meta_q <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         len_q     <= len_d;
         beats_q   <= beats_d;
         rd_q      <= rd;
         rd_meta_q <= rd_meta_d;
      end
   tx_tlp_mux_skid #(.W(SW)) u_skid (
      .clk     (clk),
      .arst    (arst),
      .push_i  (rd_q),
      .data_i  ({rdata, rd_meta_q}),
      .valid_o (bus.tlp_valid),
      .ready_i (bus.tlp_ready),
      .data_o  (skid_out),
      .cnt_o   (cnt)
   );
   assign {bus.tlp_data, out_meta} = skid_out;
   assign bus.tlp_sop  = out_meta.sop;
   assign bus.tlp_eop  = out_meta.eop;
   assign bus.tlp_keep = out_meta.keep;
endmodule
